// File: rtl/hd_xcvr_pkg.sv
// Shared state encoding and constants for the half-duplex transceiver controller.
// Optional echo checking is enabled by defining HD_XCVR_ECHO_CHECK_EN.
package hd_xcvr_pkg;

  typedef logic [2:0] hd_xcvr_state_e;

  localparam hd_xcvr_state_e StIdle    = 3'd0;
  localparam hd_xcvr_state_e StRx      = 3'd1;
  localparam hd_xcvr_state_e StTxSetup = 3'd2;
  localparam hd_xcvr_state_e StTx      = 3'd3;
  localparam hd_xcvr_state_e StTxHold  = 3'd4;
  localparam hd_xcvr_state_e StTurn    = 3'd5;

  localparam logic IdleLevel = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hd_xcvr_chan.sv
// One transceiver channel: turnaround FSM, delay counter and registered pin outputs.
// HD_XCVR_ECHO_CHECK_EN adds a loopback comparator and sticky echo_err_o.
module hd_xcvr_chan
  import hd_xcvr_pkg::*;
#(
  parameter int unsigned SwitchCycles = 5,
  parameter int unsigned TxEndCycles  = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tx_i,
  input  logic tx_enable_i,
  input  logic rx_enable_i,
  input  logic ro_i,
  output logic rx_o,
  output logic tx_active_o,
  output logic di_o,
  output logic de_o,
  output logic ren_o
`ifdef HD_XCVR_ECHO_CHECK_EN
  ,
  output logic echo_err_o
`endif
);

  localparam int unsigned SwEff    = (SwitchCycles == 0) ? 1 : SwitchCycles;
  localparam int unsigned EndEff   = (TxEndCycles == 0) ? 1 : TxEndCycles;
  localparam int unsigned CntWidth = $clog2(max_u(SwEff, EndEff) + 1);
  localparam logic [CntWidth-1:0] SwLoad  = CntWidth'(SwEff - 1);
  localparam logic [CntWidth-1:0] EndLoad = CntWidth'(EndEff - 1);

  hd_xcvr_state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic rx_d, act_d, di_d, de_d, ren_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (tx_enable_i) begin
          state_d = StTxSetup;
          cnt_d   = SwLoad;
        end else if (rx_enable_i) begin
          state_d = StRx;
        end
      end
      StRx: begin
        if (tx_enable_i) begin
          state_d = StTxSetup;
          cnt_d   = SwLoad;
        end else if (!rx_enable_i) begin
          state_d = StIdle;
        end
      end
      StTxSetup: begin
        if (!tx_enable_i) begin
          state_d = StTxHold;
          cnt_d   = EndLoad;
        end else if (cnt_q == '0) begin
          state_d = StTx;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StTx: begin
        if (!tx_enable_i) begin
          state_d = StTxHold;
          cnt_d   = EndLoad;
        end
      end
      StTxHold: begin
        if (tx_enable_i) begin
          state_d = StTx;
        end else if (cnt_q == '0) begin
          state_d = StTurn;
          cnt_d   = SwLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StTurn: begin
        // tx_enable_i is deliberately ignored until the bus has settled
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so pins change on the same edge as the state
  always_comb begin
    de_d  = (state_d == StTxSetup) || (state_d == StTx) || (state_d == StTxHold);
    act_d = (state_d == StTx);
`ifdef HD_XCVR_ECHO_CHECK_EN
    ren_d = !((state_d == StRx) || (state_d == StTx));
`else
    ren_d = (state_d != StRx);
`endif
    rx_d  = (state_d == StRx) ? ro_i : IdleLevel;
    di_d  = (state_d == StTx) ? tx_i : IdleLevel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      de_o        <= 1'b0;
      ren_o       <= 1'b1;
      di_o        <= IdleLevel;
      rx_o        <= IdleLevel;
      tx_active_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      de_o        <= de_d;
      ren_o       <= ren_d;
      di_o        <= di_d;
      rx_o        <= rx_d;
      tx_active_o <= act_d;
    end
  end

`ifdef HD_XCVR_ECHO_CHECK_EN
  logic di_d1_q, di_d2_q, act_d1_q, act_d2_q, err_d;
  logic start_tx;

  assign start_tx = (state_q == StIdle) && (state_d == StTxSetup);

  // Compare only while the receiver is live now and the delayed bit was driven in TX
  always_comb begin
    err_d = echo_err_o;
    if (tx_active_o && act_d2_q && (ro_i != di_d2_q)) begin
      err_d = 1'b1;
    end
    if (start_tx) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      di_d1_q    <= IdleLevel;
      di_d2_q    <= IdleLevel;
      act_d1_q   <= 1'b0;
      act_d2_q   <= 1'b0;
      echo_err_o <= 1'b0;
    end else begin
      di_d1_q    <= di_o;
      di_d2_q    <= di_d1_q;
      act_d1_q   <= tx_active_o;
      act_d2_q   <= act_d1_q;
      echo_err_o <= err_d;
    end
  end
`endif

endmodule

// File: rtl/hd_xcvr_ctrl.sv
// Multi-channel half-duplex RS-485 direction controller; slices vectors onto per-channel FSMs.
// Define HD_XCVR_ECHO_CHECK_EN to add per-channel echo_err_o loopback checking.
module hd_xcvr_ctrl
  import hd_xcvr_pkg::*;
#(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned SwitchCycles = 5,
  parameter int unsigned TxEndCycles  = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] tx_i,
  input  logic [NumChannels-1:0] tx_enable_i,
  input  logic [NumChannels-1:0] rx_enable_i,
  output logic [NumChannels-1:0] rx_o,
  output logic [NumChannels-1:0] tx_active_o,
  output logic [NumChannels-1:0] di_o,
  output logic [NumChannels-1:0] de_o,
  output logic [NumChannels-1:0] ren_o,
  input  logic [NumChannels-1:0] ro_i
`ifdef HD_XCVR_ECHO_CHECK_EN
  ,
  output logic [NumChannels-1:0] echo_err_o
`endif
);

  for (genvar g = 0; g < NumChannels; g++) begin : gen_chan
    hd_xcvr_chan #(
      .SwitchCycles(SwitchCycles),
      .TxEndCycles (TxEndCycles)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tx_i       (tx_i[g]),
      .tx_enable_i(tx_enable_i[g]),
      .rx_enable_i(rx_enable_i[g]),
      .ro_i       (ro_i[g]),
      .rx_o       (rx_o[g]),
      .tx_active_o(tx_active_o[g]),
      .di_o       (di_o[g]),
      .de_o       (de_o[g]),
`ifdef HD_XCVR_ECHO_CHECK_EN
      .ren_o      (ren_o[g]),
      .echo_err_o (echo_err_o[g])
`else
      .ren_o      (ren_o[g])
`endif
    );
  end

endmodule

// File: tb/tb_hd_xcvr_ctrl.sv
// Directed bench for hd_xcvr_ctrl with default parameters (2 channels, 5-cycle delays).
module tb_hd_xcvr_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [1:0] tx_i, tx_enable_i, rx_enable_i, ro_i;
  logic [1:0] rx_o, tx_active_o, di_o, de_o, ren_o;
`ifdef HD_XCVR_ECHO_CHECK_EN
  logic [1:0] echo_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hd_xcvr_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .tx_i       (tx_i),
    .tx_enable_i(tx_enable_i),
    .rx_enable_i(rx_enable_i),
    .rx_o       (rx_o),
    .tx_active_o(tx_active_o),
    .di_o       (di_o),
    .de_o       (de_o),
`ifdef HD_XCVR_ECHO_CHECK_EN
    .ren_o      (ren_o),
    .ro_i       (ro_i),
    .echo_err_o (echo_err_o)
`else
    .ren_o      (ren_o),
    .ro_i       (ro_i)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({de_o, ren_o, di_o, rx_o, tx_active_o} !== 10'b00_11_11_11_00) begin
      n_fail++;
      $display("FAIL reset: got de=%b ren=%b di=%b rx=%b act=%b required 00 11 11 11 00",
               de_o, ren_o, di_o, rx_o, tx_active_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_tx_start();
    tx_enable_i = 2'b01;
    tick();
    n_checks++;
    if ({de_o, ren_o, di_o, tx_active_o} !== 8'b01_11_11_00) begin
      n_fail++;
      $display("FAIL tx_start_setup: got de=%b ren=%b di=%b act=%b required 01 11 11 00",
               de_o, ren_o, di_o, tx_active_o);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (tx_active_o !== 2'b00 || de_o !== 2'b01) begin
        n_fail++;
        $display("FAIL tx_start_wait%0d: got act=%b de=%b required 00 01", i, tx_active_o, de_o);
      end
    end
    tick();
    n_checks++;
    if (tx_active_o !== 2'b01) begin
      n_fail++;
      $display("FAIL tx_active_rise: got %b required 01", tx_active_o);
    end
    tx_i = 2'b10;
    tick();
    n_checks++;
    if (di_o !== 2'b10 || de_o !== 2'b01 || ren_o !== 2'b11) begin
      n_fail++;
      $display("FAIL tx_forward0: got di=%b de=%b ren=%b required 10 01 11", di_o, de_o, ren_o);
    end
    tx_i = 2'b11;
    tick();
    n_checks++;
    if (di_o !== 2'b11) begin
      n_fail++;
      $display("FAIL tx_forward1: got di=%b required 11", di_o);
    end
  endtask

  task automatic test_hold_turn();
    rx_enable_i = 2'b01;
    tx_enable_i = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (de_o !== 2'b01 || tx_active_o !== 2'b00 || rx_o !== 2'b11) begin
        n_fail++;
        $display("FAIL hold%0d: got de=%b act=%b rx=%b required 01 00 11",
                 i, de_o, tx_active_o, rx_o);
      end
    end
    for (int i = 6; i <= 11; i++) begin
      tick();
      n_checks++;
      if (de_o !== 2'b00 || ren_o !== 2'b11 || rx_o !== 2'b11) begin
        n_fail++;
        $display("FAIL turn%0d: got de=%b ren=%b rx=%b required 00 11 11", i, de_o, ren_o, rx_o);
      end
    end
    ro_i = 2'b10;
    tick();
    n_checks++;
    if (ren_o !== 2'b10 || rx_o !== 2'b10 || de_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rx_enter: got ren=%b rx=%b de=%b required 10 10 00", ren_o, rx_o, de_o);
    end
    ro_i = 2'b11;
    tick();
    n_checks++;
    if (rx_o !== 2'b11) begin
      n_fail++;
      $display("FAIL rx_track: got rx=%b required 11", rx_o);
    end
    rx_enable_i = 2'b00;
    ro_i = 2'b10;
    tick();
    n_checks++;
    if (ren_o !== 2'b11 || rx_o !== 2'b11) begin
      n_fail++;
      $display("FAIL rx_exit: got ren=%b rx=%b required 11 11", ren_o, rx_o);
    end
    ro_i = 2'b11;
  endtask

  task automatic test_reentry();
    tx_enable_i = 2'b01;
    repeat (6) tick();
    tx_enable_i = 2'b00;
    tick();
    tick();
    tx_enable_i = 2'b01;
    tick();
    n_checks++;
    if (tx_active_o !== 2'b01 || de_o !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_reentry: got act=%b de=%b required 01 01", tx_active_o, de_o);
    end
    tx_enable_i = 2'b00;
    repeat (6) tick();
    tx_enable_i = 2'b01;
    for (int i = 7; i <= 11; i++) begin
      tick();
      n_checks++;
      if (de_o !== 2'b00 || tx_active_o !== 2'b00) begin
        n_fail++;
        $display("FAIL turn_holdoff%0d: got de=%b act=%b required 00 00", i, de_o, tx_active_o);
      end
    end
    tick();
    n_checks++;
    if (de_o !== 2'b01 || tx_active_o !== 2'b00) begin
      n_fail++;
      $display("FAIL turn_restart: got de=%b act=%b required 01 00", de_o, tx_active_o);
    end
    repeat (4) tick();
    n_checks++;
    if (tx_active_o !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_early: got act=%b required 00", tx_active_o);
    end
    tick();
    n_checks++;
    if (tx_active_o !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_full_setup: got act=%b required 01", tx_active_o);
    end
    tx_enable_i = 2'b00;
    repeat (12) tick();
  endtask

  task automatic test_priority();
    tx_enable_i = 2'b10;
    rx_enable_i = 2'b10;
    tick();
    n_checks++;
    if (de_o !== 2'b10 || ren_o !== 2'b11) begin
      n_fail++;
      $display("FAIL priority: got de=%b ren=%b required 10 11", de_o, ren_o);
    end
    tx_enable_i = 2'b00;
    rx_enable_i = 2'b00;
    repeat (12) tick();
    n_checks++;
    if ({de_o, ren_o, tx_active_o} !== 6'b00_11_00) begin
      n_fail++;
      $display("FAIL priority_idle: got de=%b ren=%b act=%b required 00 11 00",
               de_o, ren_o, tx_active_o);
    end
  endtask

  task automatic test_invariant_random();
    logic [1:0] bad;
    for (int i = 0; i < 10000; i++) begin
      tx_enable_i = 2'($urandom_range(0, 3));
      rx_enable_i = 2'($urandom_range(0, 3));
      tx_i        = 2'($urandom_range(0, 3));
      ro_i        = 2'($urandom_range(0, 3));
      tick();
`ifdef HD_XCVR_ECHO_CHECK_EN
      bad = de_o & ~ren_o & ~tx_active_o;
`else
      bad = de_o & ~ren_o;
`endif
      n_checks++;
      if (bad !== 2'b00) begin
        n_fail++;
        $display("FAIL invariant cycle %0d: got de=%b ren=%b required no de with ren low",
                 i, de_o, ren_o);
      end
    end
    tx_enable_i = 2'b00;
    rx_enable_i = 2'b00;
    tx_i = 2'b11;
    ro_i = 2'b11;
  endtask

  task automatic test_reset_mid_tx();
    tx_enable_i = 2'b11;
    tx_i = 2'b00;
    repeat (10) tick();
    n_checks++;
    if (tx_active_o !== 2'b11 || di_o !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_tx_pre: got act=%b di=%b required 11 00", tx_active_o, di_o);
    end
    rst_i = 1'b1;
    tick();
    n_checks++;
    if ({de_o, ren_o, di_o, rx_o, tx_active_o} !== 10'b00_11_11_11_00) begin
      n_fail++;
      $display("FAIL reset_mid_tx: got de=%b ren=%b di=%b rx=%b act=%b required 00 11 11 11 00",
               de_o, ren_o, di_o, rx_o, tx_active_o);
    end
    tx_enable_i = 2'b00;
    tx_i = 2'b11;
    rst_i = 1'b0;
    tick();
  endtask

`ifdef HD_XCVR_ECHO_CHECK_EN
  task automatic test_echo();
    ro_i = 2'b11;
    tx_i = 2'b11;
    tx_enable_i = 2'b01;
    repeat (9) tick();
    n_checks++;
    if (echo_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL echo_clean: got %b required 00", echo_err_o);
    end
    ro_i = 2'b10;
    tick();
    ro_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (echo_err_o !== 2'b01) begin
        n_fail++;
        $display("FAIL echo_sticky%0d: got %b required 01", i, echo_err_o);
      end
    end
    tx_enable_i = 2'b00;
    repeat (12) tick();
    tx_enable_i = 2'b01;
    tick();
    n_checks++;
    if (echo_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL echo_clear: got %b required 00", echo_err_o);
    end
    tx_enable_i = 2'b00;
    repeat (12) tick();
  endtask
`endif

  initial begin
    rst_i       = 1'b1;
    tx_i        = 2'b11;
    tx_enable_i = 2'b00;
    rx_enable_i = 2'b00;
    ro_i        = 2'b11;
    test_reset();
    test_tx_start();
    test_hold_turn();
    test_reentry();
    test_priority();
    test_invariant_random();
    test_reset_mid_tx();
`ifdef HD_XCVR_ECHO_CHECK_EN
    test_echo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
